ts_ym_ctrl: RTL and testbench

Parametrised TurboSound bus controller for ZX Spectrum-class hosts: decodes Z80 I/O cycles and drives the BC1/BDIR bus of 1 to 4 YM2149/AY-3-8910 chips, the chip-select lines, a divided YM clock, the covox DAC latch and the beeper/tape-out port. It generalises the dual-YM CPLD decoder to NUM_CHIPS chips, with registered bus strobes, a programmable hold phase and a programmable YM clock divider. It sits between the host edge connector and the PSG chips.

---
 rtl/ts_ym_ctrl_if.sv | 31 +++
 rtl/ts_ym_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ts_ym_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_ym_ctrl_if.sv
// rtl/ts_ym_ctrl_if.sv - Z80 host I/O bus and PSG bus signal bundle for ts_ym_ctrl
interface ts_ym_ctrl_if #(
  parameter int NUM_CHIPS = 2
);
  logic [15:0]          adr;
  logic [7:0]           d;
  logic                 iorq;
  logic                 m1;
  logic                 rd;
  logic                 wr;
  logic                 dos;
  logic                 bc1;
  logic                 bdir;
  logic [NUM_CHIPS-1:0] ym_sel;
  logic                 ym_clock;
  logic [7:0]           covox;
  logic                 beeper;
  logic                 tapeout;

  // Host side: drives the Z80 bus, observes the PSG-side outputs
  modport master (
    output adr, d, iorq, m1, rd, wr, dos,
    input  bc1, bdir, ym_sel, ym_clock, covox, beeper, tapeout
  );

  // Controller side
  modport slave (
    input  adr, d, iorq, m1, rd, wr, dos,
    output bc1, bdir, ym_sel, ym_clock, covox, beeper, tapeout
  );
endinterface

// File: rtl/ts_ym_ctrl.sv
// rtl/ts_ym_ctrl.sv - TurboSound bus controller for 1..4 PSG chips; covox latch enabled by TS_YM_COVOX_EN
module ts_ym_ctrl #(
  parameter int NUM_CHIPS   = 2,
  parameter int YM_CLK_DIV  = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic        cpu_clock,
  input  logic        reset,
  ts_ym_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam int                   HALF_DIV  = YM_CLK_DIV / 2;
  localparam int                   DIV_W     = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(HALF_DIV - 1);
  localparam logic [1:0]           HOLD_LAST = 2'(HOLD_CYCLES);
  localparam logic [NUM_CHIPS-1:0] SEL_RST   = NUM_CHIPS'(1);

  logic [1:0]           state_q, state_d;
  logic [1:0]           hold_q, hold_d;
  logic                 bc1_q, bc1_d;
  logic                 bdir_q, bdir_d;
  logic [NUM_CHIPS-1:0] sel_q, sel_d;
  logic                 busy_q;
  logic [DIV_W-1:0]     div_q;
  logic                 ymclk_q;
  logic [7:0]           covox_q;
  logic                 beeper_q;
  logic                 tapeout_q;

  logic       cyc_on, cyc_valid, cyc_fresh, is_write;
  logic       hit_reg, hit_dat, hit_cov, hit_beep;
  logic       sel_write, sel_in_range, bus_start;
  logic [1:0] sel_idx;

  // Address bits outside the partial decode are deliberately ignored
  logic unused_adr;
  assign unused_adr = ^bus.adr[13:2];

  // Cycle qualification and port decode
  always_comb begin
    cyc_on    = !bus.iorq && (!bus.rd || !bus.wr);
    cyc_valid = !bus.iorq && bus.m1 && bus.dos && (bus.rd ^ bus.wr);
    cyc_fresh = cyc_valid && !busy_q;
    is_write  = !bus.wr;
    hit_reg   = bus.adr[15] && bus.adr[14] && !bus.adr[1] && bus.adr[0];
    hit_dat   = bus.adr[15] && !bus.adr[14] && !bus.adr[1] && bus.adr[0];
`ifdef TS_YM_COVOX_EN
    hit_cov   = (bus.adr[7:0] == 8'hFB);
`else
    hit_cov   = 1'b0;
`endif
    hit_beep     = !bus.adr[0];
    sel_idx      = ~bus.d[1:0];
    sel_write    = is_write && hit_reg && (bus.d[7:2] == 6'h3F);
    sel_in_range = ({1'b0, sel_idx} < 3'(NUM_CHIPS));
    bus_start    = cyc_fresh && (hit_reg || hit_dat) && !sel_write;
  end

  // Each host cycle acts once; reset marks the current cycle as already consumed
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) busy_q <= 1'b1;
    else       busy_q <= cyc_on && (busy_q || cyc_valid);
  end

  // Strobe FSM: register bc1/bdir on the sampling edge, stretch them through HOLD
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    bc1_d   = bc1_q;
    bdir_d  = bdir_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_start) begin
          state_d = ST_ACTIVE;
          bc1_d   = hit_reg;
          bdir_d  = is_write;
        end
      end
      ST_ACTIVE: begin
        if (!cyc_on) begin
          if (HOLD_CYCLES == 0) begin
            state_d = ST_IDLE;
            bc1_d   = 1'b0;
            bdir_d  = 1'b0;
          end else begin
            state_d = ST_HOLD;
            hold_d  = 2'd1;
          end
        end
      end
      ST_HOLD: begin
        if (bus_start) begin
          state_d = ST_ACTIVE;
          hold_d  = 2'd0;
          bc1_d   = hit_reg;
          bdir_d  = is_write;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          hold_d  = 2'd0;
          bc1_d   = 1'b0;
          bdir_d  = 1'b0;
        end else begin
          hold_d = hold_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = 2'd0;
        bc1_d   = 1'b0;
        bdir_d  = 1'b0;
      end
    endcase
  end

  // Chip-select write: one-hot select of chip ~d[1:0] when it exists
  always_comb begin
    sel_d = sel_q;
    if (cyc_fresh && sel_write && sel_in_range) begin
      for (int i = 0; i < NUM_CHIPS; i++) sel_d[i] = (sel_idx == 2'(i));
    end
  end

  // FSM, strobe and select registers
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= 2'd0;
      bc1_q   <= 1'b0;
      bdir_q  <= 1'b0;
      sel_q   <= SEL_RST;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      bc1_q   <= bc1_d;
      bdir_q  <= bdir_d;
      sel_q   <= sel_d;
    end
  end

  // Covox and port 0xFE latches, taken on the first edge of a fresh write
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      covox_q   <= 8'h00;
      beeper_q  <= 1'b0;
      tapeout_q <= 1'b0;
    end else if (cyc_fresh && is_write) begin
      if (hit_cov) covox_q <= bus.d;
      if (hit_beep) begin
        beeper_q  <= bus.d[4];
        tapeout_q <= bus.d[3];
      end
    end
  end

  // Free-running divider: ym_clock toggles every YM_CLK_DIV/2 cpu_clock cycles
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      ymclk_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q   <= '0;
      ymclk_q <= ~ymclk_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign bus.bc1      = bc1_q;
  assign bus.bdir     = bdir_q;
  assign bus.ym_sel   = sel_q;
  assign bus.ym_clock = ymclk_q;
  assign bus.covox    = covox_q;
  assign bus.beeper   = beeper_q;
  assign bus.tapeout  = tapeout_q;
endmodule

// File: tb/tb_ts_ym_ctrl.sv
// tb/tb_ts_ym_ctrl.sv - Table-driven, random and corner-case bench for ts_ym_ctrl
module tb_ts_ym_ctrl;
  localparam int NUM_CHIPS   = 2;
  localparam int YM_CLK_DIV  = 2;
  localparam int HOLD_CYCLES = 1;
  localparam int HALF_DIV    = YM_CLK_DIV / 2;
`ifdef TS_YM_COVOX_EN
  localparam bit COVOX_ON = 1'b1;
`else
  localparam bit COVOX_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] adr;
    logic [7:0]  d;
    bit          w;
    bit          m1;
    bit          dos;
    bit          e_bc1;
    bit          e_bdir;
    logic [1:0]  e_sel;
    logic [7:0]  e_cov;
    bit          e_beep;
    bit          e_tape;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int         m_sel;
  logic [7:0] m_cov;
  bit         m_beep;
  bit         m_tape;

  vec_t vecs[20];

  ts_ym_ctrl_if #(.NUM_CHIPS(NUM_CHIPS)) bus ();

  ts_ym_ctrl #(
    .NUM_CHIPS  (NUM_CHIPS),
    .YM_CLK_DIV (YM_CLK_DIV),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .cpu_clock(clk),
    .reset    (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.iorq = 1'b1;
    bus.rd   = 1'b1;
    bus.wr   = 1'b1;
    bus.m1   = 1'b1;
    bus.dos  = 1'b1;
  endtask

  // Reference model: applies the decode rules to one complete host cycle
  task automatic model_cycle(input logic [15:0] a, input logic [7:0] dd, input bit w,
                             input bit m1v, input bit dosv, output bit e_bc1, output bit e_bdir);
    bit ok, is_reg, is_dat, is_sel;
    int idx;
    ok     = m1v && dosv;
    is_reg = (a[15:14] == 2'b11) && (a[1:0] == 2'b01);
    is_dat = (a[15:14] == 2'b10) && (a[1:0] == 2'b01);
    is_sel = ok && w && is_reg && (dd[7:2] == 6'b111111);
    idx    = 3 - int'(dd[1:0]);
    e_bc1  = 1'b0;
    e_bdir = 1'b0;
    if (ok && !is_sel && (is_reg || is_dat)) begin
      e_bc1  = is_reg;
      e_bdir = w;
    end
    if (is_sel && idx < NUM_CHIPS) m_sel = idx;
    if (ok && w && COVOX_ON && a[7:0] == 8'hFB) m_cov = dd;
    if (ok && w && !a[0]) begin
      m_beep = dd[4];
      m_tape = dd[3];
    end
  endtask

  // Runs one host cycle starting at a negedge and ends at a negedge with the bus idle
  task automatic run_cycle(input logic [15:0] a, input logic [7:0] dd, input bit w,
                           input bit m1v, input bit dosv, input int len,
                           input bit e_bc1, input bit e_bdir, input string tag);
    bus.adr  = a;
    bus.d    = dd;
    bus.m1   = m1v;
    bus.dos  = dosv;
    bus.rd   = w;
    bus.wr   = !w;
    bus.iorq = 1'b0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk({tag, " bc1 active"}, bus.bc1, e_bc1);
        chk({tag, " bdir active"}, bus.bdir, e_bdir);
      end
    end
    bus_idle();
    for (int k = 0; k < HOLD_CYCLES; k++) begin
      @(negedge clk);
      chk({tag, " bc1 hold"}, bus.bc1, e_bc1);
      chk({tag, " bdir hold"}, bus.bdir, e_bdir);
    end
    @(negedge clk);
    chk({tag, " bc1 idle"}, bus.bc1, 1'b0);
    chk({tag, " bdir idle"}, bus.bdir, 1'b0);
  endtask

  task automatic check_model_state(input string tag);
    logic [NUM_CHIPS-1:0] onehot;
    onehot        = '0;
    onehot[m_sel] = 1'b1;
    chk({tag, " ym_sel"}, bus.ym_sel, onehot);
    chk({tag, " covox"}, bus.covox, m_cov);
    chk({tag, " beeper"}, bus.beeper, m_beep);
    chk({tag, " tapeout"}, bus.tapeout, m_tape);
  endtask

  initial begin
    logic [7:0] cova;
    logic [15:0] a;
    logic [7:0]  dd;
    bit          w, m1v, dosv, eb1, ebd;
    int          len, pick;
    string       tag;

    cova = COVOX_ON ? 8'hA5 : 8'h00;
    vecs[0]  = '{16'hFFFD, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFD, 8'hFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{16'hFFFD, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{16'hFFFD, 8'hFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{16'hFFFD, 8'hFD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{16'hFFFD, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{16'hBFFD, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{16'hBFFD, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{16'h7FFD, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{16'hFFFD, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{16'hBFFD, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{16'hFFFD, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{16'h00FB, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, cova,  1'b0, 1'b0};
    vecs[13] = '{16'h00FE, 8'h18, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, cova,  1'b1, 1'b1};
    vecs[14] = '{16'h00FE, 8'h08, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, cova,  1'b0, 1'b1};
    vecs[15] = '{16'h00FE, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, cova,  1'b0, 1'b1};
    vecs[16] = '{16'hFFFD, 8'hFC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, cova,  1'b0, 1'b1};
    vecs[17] = '{16'hFFFD, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, cova,  1'b0, 1'b1};
    vecs[18] = '{16'hC3FD, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, cova,  1'b0, 1'b1};
    vecs[19] = '{16'h00FE, 8'hF7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, cova,  1'b1, 1'b0};

    bus_idle();
    bus.adr = 16'h0000;
    bus.d   = 8'h00;
    rst     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset bc1", bus.bc1, 1'b0);
    chk("reset bdir", bus.bdir, 1'b0);
    chk("reset ym_sel", bus.ym_sel, 2'b01);
    chk("reset covox", bus.covox, 8'h00);
    chk("reset beeper", bus.beeper, 1'b0);
    chk("reset tapeout", bus.tapeout, 1'b0);
    chk("reset ym_clock", bus.ym_clock, 1'b0);
    rst = 1'b0;

    // ym_clock after m rising edges is (m / (DIV/2)) mod 2
    for (int m = 1; m <= 4 * YM_CLK_DIV; m++) begin
      @(negedge clk);
      chk($sformatf("ym_clock edge %0d", m), bus.ym_clock, 32'((m / HALF_DIV) % 2));
    end

    foreach (vecs[i]) begin
      tag = $sformatf("vec%0d", i);
      run_cycle(vecs[i].adr, vecs[i].d, vecs[i].w, vecs[i].m1, vecs[i].dos, 2,
                vecs[i].e_bc1, vecs[i].e_bdir, tag);
      chk({tag, " ym_sel"}, bus.ym_sel, vecs[i].e_sel);
      chk({tag, " covox"}, bus.covox, vecs[i].e_cov);
      chk({tag, " beeper"}, bus.beeper, vecs[i].e_beep);
      chk({tag, " tapeout"}, bus.tapeout, vecs[i].e_tape);
    end
    m_sel  = 0;
    m_cov  = cova;
    m_beep = 1'b1;
    m_tape = 1'b0;

    for (int n = 0; n < 150; n++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0:       a = {2'b11, 12'($urandom), 2'b01};
        1:       a = {2'b10, 12'($urandom), 2'b01};
        2:       a = 16'h7FFD;
        3:       a = {8'($urandom), 8'hFB};
        4:       a = {15'($urandom), 1'b0};
        default: a = 16'($urandom);
      endcase
      dd   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(252, 255)) : 8'($urandom);
      w    = ($urandom_range(0, 1) == 1);
      m1v  = ($urandom_range(0, 7) != 0);
      dosv = ($urandom_range(0, 7) != 0);
      len  = $urandom_range(1, 3);
      tag  = $sformatf("rnd%0d", n);
      model_cycle(a, dd, w, m1v, dosv, eb1, ebd);
      run_cycle(a, dd, w, m1v, dosv, len, eb1, ebd, tag);
      check_model_state(tag);
    end

    // New cycle during HOLD takes over immediately with its own codes
    bus.adr = 16'hFFFD; bus.d = 8'h07; bus.rd = 1'b1; bus.wr = 1'b0; bus.iorq = 1'b0;
    @(negedge clk);
    chk("b2b first bc1", bus.bc1, 1'b1);
    chk("b2b first bdir", bus.bdir, 1'b1);
    bus_idle();
    @(negedge clk);
    chk("b2b hold bc1", bus.bc1, 1'b1);
    bus.adr = 16'hBFFD; bus.d = 8'h01; bus.rd = 1'b1; bus.wr = 1'b0; bus.iorq = 1'b0;
    @(negedge clk);
    chk("b2b second bc1", bus.bc1, 1'b0);
    chk("b2b second bdir", bus.bdir, 1'b1);
    bus_idle();
    @(negedge clk);
    @(negedge clk);
    chk("b2b end bdir", bus.bdir, 1'b0);

    // Reset in the middle of an active REG write
    run_cycle(16'hFFFD, 8'hFE, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, "presel");
    chk("presel ym_sel", bus.ym_sel, 2'b10);
    bus.adr = 16'hFFFD; bus.d = 8'h07; bus.rd = 1'b1; bus.wr = 1'b0; bus.iorq = 1'b0;
    @(negedge clk);
    chk("midrst before bdir", bus.bdir, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst async bdir", bus.bdir, 1'b0);
    chk("midrst async bc1", bus.bc1, 1'b0);
    chk("midrst async ym_sel", bus.ym_sel, 2'b01);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrst stuck bdir %0d", k), bus.bdir, 1'b0);
      chk($sformatf("midrst stuck bc1 %0d", k), bus.bc1, 1'b0);
    end
    bus_idle();
    @(negedge clk);
    run_cycle(16'hFFFD, 8'h07, 1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b1, "postrst");

    // Reset after a port 0xFE latch: held strobes must not relatch after release
    bus.adr = 16'h00FE; bus.d = 8'h18; bus.rd = 1'b1; bus.wr = 1'b0; bus.iorq = 1'b0;
    @(negedge clk);
    chk("beeprst latched", bus.beeper, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("beeprst async beeper", bus.beeper, 1'b0);
    chk("beeprst async tapeout", bus.tapeout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("beeprst stuck beeper %0d", k), bus.beeper, 1'b0);
      chk($sformatf("beeprst stuck tapeout %0d", k), bus.tapeout, 1'b0);
    end
    bus_idle();
    @(negedge clk);
    chk("beeprst covox", bus.covox, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
